// File: rtl/rng_segment_eval_pkg.sv
// Shared definitions for the RNG segment evaluator: default widths and
// field-layout / address-width helpers used by the float sample decoder.
package rng_segment_eval_pkg;

  // Default configuration of the non-uniform RNG back end
  localparam int URNG_BX             = 16;
  localparam int RNG_BY              = 16;
  localparam int RNG_K               = 2;
  localparam int RNG_MANT_BW         = 8;
  localparam int RNG_EXP_BW          = 6;
  localparam int RNG_GROWING_OCT     = 6;
  localparam int RNG_DIMINISHING_OCT = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to number every section (growing + diminishing)
  function automatic int sec_bw(input int g_oct, input int d_oct);
    return max_int(1, $clog2(g_oct + d_oct));
  endfunction

  // Coefficient address width: section index concatenated with subsection
  function automatic int addr_bw(input int g_oct, input int d_oct, input int k);
    return sec_bw(g_oct, d_oct) + k;
  endfunction

  // Float sample field positions: [bx-1]=symm, [bx-2]=part, exponent, mantissa
  function automatic int symm_pos(input int bx);
    return bx - 1;
  endfunction

  function automatic int part_pos(input int bx);
    return bx - 2;
  endfunction

endpackage

// File: rtl/rng_segment_eval_out.sv
// Small output FIFO for the segment evaluator: power-of-two depth,
// synchronous reset, simultaneous push/pop, head reads 0 when empty.
module rng_out_fifo
  import rng_segment_eval_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTRW = max_int(1, $clog2(DEPTH));
  localparam logic [$clog2(DEPTH):0] FULL = ($clog2(DEPTH) + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pops on an empty FIFO are ignored; a push into a full FIFO only lands if a pop frees a slot
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL) || do_pop);
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Head is forced to zero while empty so the output never shows stale data
  always_comb begin
    head = (count != '0) ? mem[rd_ptr] : '0;
  end

endmodule

// File: rtl/rng_segment_eval.sv
// Segment evaluator: decodes a float-encoded uniform sample into a coefficient
// address, evaluates y = c0 + c1*frac with saturation and symmetry sign, and
// delivers results through a credit-controlled output FIFO.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid, and valid/data hold until taken.
module rng_segment_eval
  import rng_segment_eval_pkg::*;
#(
  parameter int BX         = URNG_BX,
  parameter int BY         = RNG_BY,
  parameter int K          = RNG_K,
  parameter int MANT_BW    = RNG_MANT_BW,
  parameter int EXP_BW     = RNG_EXP_BW,
  parameter int G_OCT      = RNG_GROWING_OCT,
  parameter int D_OCT      = RNG_DIMINISHING_OCT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [BX-1:0]                          in_sample,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [addr_bw(G_OCT, D_OCT, K)-1:0]    lookup_addr,
  output logic                                   lookup_en,
  input  logic signed [BY-1:0]                   c0,
  input  logic signed [BY-1:0]                   c1,
  output logic [BY-1:0]                          out_sample,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   clamp_flag
);

  localparam int FW   = MANT_BW - K;          // fraction bits below the subsection index
  localparam int SECW = sec_bw(G_OCT, D_OCT);
  localparam int AW   = SECW + K;
  localparam int PW   = BY + FW + 1;          // full signed x unsigned product width
  localparam int SW   = BY + FW + 2;          // sum width before saturation
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int OW   = CW + 3;               // FIFO count plus up to four in-flight samples

  localparam logic [EXP_BW-1:0] G_LAST = EXP_BW'(G_OCT - 1);
  localparam logic [EXP_BW-1:0] D_LAST = EXP_BW'(D_OCT - 1);
  localparam logic [SECW-1:0]   G_SEC  = SECW'(G_OCT);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-BY+1){1'b0}}, {(BY-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-BY+1){1'b1}}, {(BY-1){1'b0}}};
  localparam logic [BY-1:0] Y_MIN = {1'b1, {(BY-1){1'b0}}};
  localparam logic [BY-1:0] Y_MAX = {1'b0, {(BY-1){1'b1}}};
  localparam logic [OW-1:0] DEPTH_W = OW'(FIFO_DEPTH);

  // Input field decode
  logic              in_symm;
  logic              in_part;
  logic [EXP_BW-1:0] in_exp;
  logic [K-1:0]      in_sub;
  logic [FW-1:0]     in_frac;
  logic [EXP_BW-1:0] e_last;
  logic [EXP_BW-1:0] e_clamped;
  logic              clamp_hit;
  logic [SECW-1:0]   section;
  logic [AW-1:0]     addr_next;
  logic              accept;

  // Stage 1: address issued, symm/frac held
  logic              s1_symm;
  logic [FW-1:0]     s1_frac;
  // Stage 1b: waiting one cycle for the coefficient read
  logic              s1b_valid;
  logic              s1b_symm;
  logic [FW-1:0]     s1b_frac;
  // Stage 2: coefficients captured
  logic              s2_valid;
  logic              s2_symm;
  logic [FW-1:0]     s2_frac;
  logic signed [BY-1:0] s2_c0;
  logic signed [BY-1:0] s2_c1;
  // Stage 3: scaled product registered
  logic              s3_valid;
  logic              s3_symm;
  logic signed [BY-1:0] s3_c0;
  logic signed [BY:0]   s3_p;

  logic signed [PW-1:0] c1_ext;
  logic signed [PW-1:0] frac_ext;
  logic signed [PW-1:0] prod;
  logic signed [BY:0]   p_next;
  logic                 unused_prod_lsbs;

  logic signed [SW-1:0] c0_ext;
  logic signed [SW-1:0] p_ext;
  logic signed [SW-1:0] sum;
  logic [BY-1:0]        sat;
  logic [BY-1:0]        y;

  logic [CW-1:0]        fifo_count;
  logic [OW-1:0]        inflight;
  logic [OW-1:0]        occupancy;

  // Split the float sample, clamp the exponent to the part's section count, form the address
  always_comb begin
    in_symm   = in_sample[symm_pos(BX)];
    in_part   = in_sample[part_pos(BX)];
    in_exp    = in_sample[MANT_BW +: EXP_BW];
    in_sub    = in_sample[MANT_BW-1 -: K];
    in_frac   = in_sample[FW-1:0];
    e_last    = in_part ? D_LAST : G_LAST;
    clamp_hit = (in_exp > e_last);
    e_clamped = clamp_hit ? e_last : in_exp;
    section   = in_part ? (G_SEC + SECW'(e_clamped)) : SECW'(e_clamped);
    addr_next = {section, in_sub};
    accept    = in_valid && in_ready && !rst;
  end

  // Four-stage evaluation pipeline; it never stalls because input credits bound occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_en   <= 1'b0;
      lookup_addr <= '0;
      s1_symm     <= 1'b0;
      s1_frac     <= '0;
      s1b_valid   <= 1'b0;
      s1b_symm    <= 1'b0;
      s1b_frac    <= '0;
      s2_valid    <= 1'b0;
      s2_symm     <= 1'b0;
      s2_frac     <= '0;
      s2_c0       <= '0;
      s2_c1       <= '0;
      s3_valid    <= 1'b0;
      s3_symm     <= 1'b0;
      s3_c0       <= '0;
      s3_p        <= '0;
    end else begin
      lookup_en <= accept;
      if (accept) begin
        lookup_addr <= addr_next;
        s1_symm     <= in_symm;
        s1_frac     <= in_frac;
      end
      s1b_valid <= lookup_en;
      s1b_symm  <= s1_symm;
      s1b_frac  <= s1_frac;
      s2_valid  <= s1b_valid;
      s2_symm   <= s1b_symm;
      s2_frac   <= s1b_frac;
      s2_c0     <= c0;
      s2_c1     <= c1;
      s3_valid  <= s2_valid;
      s3_symm   <= s2_symm;
      s3_c0     <= s2_c0;
      s3_p      <= p_next;
    end
  end

  // Sticky record of any exponent that had to be clamped
  always_ff @(posedge clk) begin
    if (rst) begin
      clamp_flag <= 1'b0;
    end else if (accept && clamp_hit) begin
      clamp_flag <= 1'b1;
    end
  end

  // c1 * frac; keeping the top bits is an arithmetic shift right by FW (floor)
  always_comb begin
    c1_ext   = {{(PW-BY){s2_c1[BY-1]}}, s2_c1};
    frac_ext = {{(PW-FW){1'b0}}, s2_frac};
    prod     = c1_ext * frac_ext;
    p_next   = prod[PW-1:FW];
  end
  assign unused_prod_lsbs = ^prod[FW-1:0];

  // Sum, saturate to BY bits, then apply the symmetry sign with -MIN saturating to MAX
  always_comb begin
    c0_ext = {{(SW-BY){s3_c0[BY-1]}}, s3_c0};
    p_ext  = {{(SW-BY-1){s3_p[BY]}}, s3_p};
    sum    = c0_ext + p_ext;
    if (sum > SAT_MAX) begin
      sat = Y_MAX;
    end else if (sum < SAT_MIN) begin
      sat = Y_MIN;
    end else begin
      sat = sum[BY-1:0];
    end
    if (s3_symm) begin
      y = (sat == Y_MIN) ? Y_MAX : (-sat);
    end else begin
      y = sat;
    end
  end

  // Credit check: every sample in the pipeline owns a FIFO slot in advance.
  // A sample holds its credit for four pipeline cycles plus at least one FIFO
  // cycle, so sustained one-per-cycle flow needs FIFO_DEPTH of at least five.
  always_comb begin
    inflight  = OW'(lookup_en) + OW'(s1b_valid) + OW'(s2_valid) + OW'(s3_valid);
    occupancy = OW'(fifo_count) + inflight;
    in_ready  = (occupancy < DEPTH_W);
    out_valid = (fifo_count != '0);
  end

  rng_out_fifo #(
    .WIDTH (BY),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s3_valid),
    .push_data (y),
    .pop       (out_ready),
    .head      (out_sample),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_rng_segment_eval.sv
// Bench for rng_segment_eval: directed vector table with exact timing checks,
// then backpressure, streaming and mid-stream reset sequences.
module tb_rng_segment_eval;

  localparam int BX = 16, BY = 16, K = 2, MANT_BW = 8, EXP_BW = 6;
  localparam int G_OCT = 6, D_OCT = 4, FIFO_DEPTH = 4;

  // Clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [BX-1:0]        in_sample = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [5:0]           lookup_addr;
  logic                 lookup_en;
  logic signed [BY-1:0] c0 = '0;
  logic signed [BY-1:0] c1 = '0;
  logic [BY-1:0]        out_sample;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 clamp_flag;

  rng_segment_eval #(
    .BX(BX), .BY(BY), .K(K), .MANT_BW(MANT_BW), .EXP_BW(EXP_BW),
    .G_OCT(G_OCT), .D_OCT(D_OCT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
    .lookup_addr(lookup_addr), .lookup_en(lookup_en),
    .c0(c0), .c1(c1),
    .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
    .clamp_flag(clamp_flag)
  );

  // Coefficient table contents
  function automatic logic signed [15:0] coef_c0(input int a);
    if (a == 9)  return 16'sh0100;
    if (a == 37) return 16'sh7FF0;
    return 16'((a * 1237) ^ 32'h5A5A);
  endfunction

  function automatic logic signed [15:0] coef_c1(input int a);
    if (a == 9)  return 16'sh0040;
    if (a == 37) return 16'sh0200;
    return 16'(a * 977 - 20000);
  endfunction

  // Lookup memory: one-cycle read latency after the strobe
  always @(posedge clk) begin
    if (lookup_en) begin
      c0 <= coef_c0(int'(lookup_addr));
      c1 <= coef_c1(int'(lookup_addr));
    end
  end

  // Reference model, integer arithmetic
  function automatic int ref_addr(input logic [15:0] s);
    int e, n, sec;
    e   = int'(s[13:8]);
    n   = s[14] ? D_OCT : G_OCT;
    if (e > n - 1) e = n - 1;
    sec = s[14] ? (G_OCT + e) : e;
    return sec * 4 + int'(s[7:6]);
  endfunction

  function automatic logic [15:0] ref_y(input logic [15:0] s);
    int a, frac, c0v, c1v, p, sv;
    a    = ref_addr(s);
    frac = int'(s[5:0]);
    c0v  = int'(coef_c0(a));
    c1v  = int'(coef_c1(a));
    p    = (c1v * frac) >>> 6;
    sv   = c0v + p;
    if (sv > 32767)  sv = 32767;
    if (sv < -32768) sv = -32768;
    if (s[15]) sv = (sv == -32768) ? 32767 : -sv;
    return 16'(sv);
  endfunction

  // Scoreboard
  logic [BY-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int n_out = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Output monitor: every handshake must match the next expected sample
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0h expected none", out_sample);
      end else begin
        check("out_order", 32'(out_sample), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      tick();
      b++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [15:0] smp;
    logic [5:0]  addr;
    logic [15:0] y;
    logic        clamp;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int i);
    check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
    in_sample = vecs[i].smp;
    in_valid  = 1'b1;
    exp_q.push_back(vecs[i].y);
    tick();
    in_valid = 1'b0;
    check($sformatf("v%0d_lookup_en", i), 32'(lookup_en), 32'd1);
    check($sformatf("v%0d_lookup_addr", i), 32'(lookup_addr), 32'(vecs[i].addr));
    tick();
    check($sformatf("v%0d_lookup_en_drop", i), 32'(lookup_en), 32'd0);
    tick();
    tick();
    check($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
    tick();
    check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
    check($sformatf("v%0d_out_sample", i), 32'(out_sample), 32'(vecs[i].y));
    check($sformatf("v%0d_clamp_flag", i), 32'(clamp_flag), 32'(vecs[i].clamp));
    tick();
    check($sformatf("v%0d_popped", i), 32'(out_valid), 32'd0);
  endtask

  initial begin
    int nacc, n0, b;
    logic [15:0] s;

    // Reset values
    repeat (3) tick();
    check("rst_lookup_en", 32'(lookup_en), 32'd0);
    check("rst_lookup_addr", 32'(lookup_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sample", 32'(out_sample), 32'd0);
    check("rst_clamp_flag", 32'(clamp_flag), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors (hand-computed): {symm,part,exp[5:0],mant[7:0]}
    vecs[0] = '{16'h0500, 6'd20, 16'h3AFE, 1'b0}; // part0 exp=N-1 boundary, frac 0
    vecs[1] = '{16'h43C0, 6'd39, 16'hE629, 1'b0}; // part1 exp=N-1 boundary, sub 3
    vecs[2] = '{16'h0260, 6'd9,  16'h0120, 1'b0}; // basic
    vecs[3] = '{16'h8260, 6'd9,  16'hFEE0, 1'b0}; // sign
    vecs[4] = '{16'h477F, 6'd37, 16'h7FFF, 1'b1}; // clamp exp 7->3, positive saturation
    vecs[5] = '{16'hC77F, 6'd37, 16'h8001, 1'b1}; // same, negated
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) run_vec(i);

    // Backpressure: only FIFO_DEPTH samples accepted with the consumer stalled
    out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      s = 16'($urandom_range(0, 16'hFFFF));
      in_sample = s;
      in_valid  = 1'b1;
      if (in_ready) begin
        nacc++;
        exp_q.push_back(ref_y(s));
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(nacc), 32'd4);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (6) tick();
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_still_blocked", 32'(in_ready), 32'd0);
    n0 = n_out;
    out_ready = 1'b1;
    drain("bp_drain");
    check("bp_out_count", 32'(n_out - n0), 32'd4);
    tick();
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Streaming: 20 samples, consumer always ready
    n0 = n_out;
    for (int i = 0; i < 20; i++) begin
      s = 16'($urandom_range(0, 16'hFFFF));
      in_sample = s;
      in_valid  = 1'b1;
      b = 0;
      while (!in_ready && b < 50) begin
        tick();
        b++;
      end
      exp_q.push_back(ref_y(s));
      tick();
    end
    in_valid = 1'b0;
    drain("stream_drain");
    check("stream_out_count", 32'(n_out - n0), 32'd20);

    // Reset with three samples in flight
    for (int i = 0; i < 3; i++) begin
      in_sample = vecs[4 + (i % 2)].smp;
      in_valid  = 1'b1;
      exp_q.push_back(vecs[4 + (i % 2)].y);
      tick();
    end
    check("pre_rst_clamp_flag", 32'(clamp_flag), 32'd1);
    in_sample = vecs[2].smp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    n0 = n_out;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_clamp_flag", 32'(clamp_flag), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_lookup_en", 32'(lookup_en), 32'd0);
    check("mid_rst_lookup_addr", 32'(lookup_addr), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("post_rst_quiet%0d", i), 32'(out_valid), 32'd0);
    end
    check("post_rst_no_outputs", 32'(n_out - n0), 32'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
